// File: rtl/adder_result_display.sv
// adder_result_display
//   Display stage behind the 4-bit ripple-carry adder. On a load strobe it
//   captures both operands and the 5-bit result {cout, sum}. It then
//   time-multiplexes four 7-segment digits. From left to right the digits are:
//   operand A (hex), operand B (hex), result tens, result ones.
//
// Ports
//   clk     in   1  system clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   load    in   1  capture strobe, sampled on every clk edge
//   op_a    in   4  operand A
//   op_b    in   4  operand B
//   sum     in   4  adder sum bits
//   cout    in   1  adder carry-out
//   seg     out  7  segments {g,f,e,d,c,b,a}
//   dp      out  1  decimal point; lit on the ones digit when the result carried
//   dig_en  out  4  one-hot digit enable, bit 3 = leftmost digit
//   valid   out  1  sticky: at least one load captured since reset
//
// Parameters
//   SCAN_DIV        cycles each digit stays enabled (>= 1)
//   SEG_ACTIVE_LOW  1 = seg/dp pins low-true
//   DIG_ACTIVE_LOW  1 = dig_en pins low-true
module adder_result_display #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic [3:0] sum,
  input  logic       cout,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig_en,
  output logic       valid
);

  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic          SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic          DIG_INV  = (DIG_ACTIVE_LOW != 0);

  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic [4:0]    res_q;
  logic          valid_q;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          tc;

  logic [1:0]    tens;
  logic [4:0]    ones_w;
  logic [3:0]    ones;
  logic [6:0]    seg_on;
  logic          dp_on;
  logic [3:0]    dig_on;

  // Active-high gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  assign tc    = (cnt == CNT_LAST);
  assign valid = valid_q;

  // Capture registers; valid is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      a_q     <= op_a;
      b_q     <= op_b;
      res_q   <= {cout, sum};
      valid_q <= 1'b1;
    end
  end

  // Scan counter: the digit index advances on the terminal-count cycle.
  // The scan keeps running while nothing is captured, and a load never restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc) idx <= idx + 2'd1;
    end
  end

  // Split the result into decimal digits by thresholds (no divider).
  // 31 cannot come from the adder; it falls into the ">= 30" bucket and shows as "31".
  always_comb begin
    tens   = 2'd0;
    ones_w = res_q;
    if (res_q >= 5'd30) begin
      tens   = 2'd3;
      ones_w = res_q - 5'd30;
    end else if (res_q >= 5'd20) begin
      tens   = 2'd2;
      ones_w = res_q - 5'd20;
    end else if (res_q >= 5'd10) begin
      tens   = 2'd1;
      ones_w = res_q - 5'd10;
    end
    ones = ones_w[3:0];
  end

  // Active-high content of the currently indexed digit.
  always_comb begin
    seg_on = '0;
    dp_on  = 1'b0;
    dig_on = '0;
    if (valid_q) begin
      dig_on = 4'b0001 << idx;
      case (idx)
        2'd3: seg_on = hex7(a_q);
        2'd2: seg_on = hex7(b_q);
        2'd1: seg_on = (tens == 2'd0) ? 7'h00 : hex7({2'b00, tens});
        default: begin
          seg_on = hex7(ones);
          dp_on  = res_q[4];
        end
      endcase
    end
  end

  // A single output register stage. seg, dp and dig_en all move on the same
  // edge, so a segment pattern is never shown on the wrong digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= {7{SEG_INV}};
      dp     <= SEG_INV;
      dig_en <= {4{DIG_INV}};
    end else begin
      seg    <= seg_on ^ {7{SEG_INV}};
      dp     <= dp_on ^ SEG_INV;
      dig_en <= dig_on ^ {4{DIG_INV}};
    end
  end

endmodule

// File: tb/tb_adder_result_display.sv
module tb_adder_result_display;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] sum;
  logic       cout;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig_en;
  logic       valid;

  int total = 0;
  int bad   = 0;

  // Scoreboard entry per clock edge: {valid, dig_en, dp, seg}
  logic [12:0] exp_q[$];

  // Reference model state
  int m_edges;
  bit m_valid;
  int m_a, m_b, m_res;

  logic [6:0] hex_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  adder_result_display #(
    .SCAN_DIV(SCAN_DIV),
    .SEG_ACTIVE_LOW(0),
    .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .op_a(op_a), .op_b(op_b),
    .sum(sum), .cout(cout), .seg(seg), .dp(dp), .dig_en(dig_en), .valid(valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Display after n edges of scanning: digit position = (n / SCAN_DIV) mod 4.
  function automatic logic [11:0] model_out(int n, bit v, int a, int b, int res);
    int d;
    int tens;
    int ones;
    logic [6:0] s;
    logic p;
    if (!v) return 12'h000;
    d    = (n / SCAN_DIV) % 4;
    tens = res / 10;
    ones = res % 10;
    p    = 1'b0;
    case (d)
      3: s = hex_tab[a];
      2: s = hex_tab[b];
      1: s = (tens == 0) ? 7'h00 : hex_tab[tens];
      default: begin
        s = hex_tab[ones];
        p = (res >= 16);
      end
    endcase
    return {4'(1 << d), p, s};
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_valid = 0;
    m_a = 0;
    m_b = 0;
    m_res = 0;
    exp_q.delete();
  endtask

  // Advance one clock edge, pushing the expectation for the outputs that
  // follow this edge, and then update the model with whatever this edge captured.
  task automatic tick();
    logic [11:0] o;
    @(posedge clk);
    o = model_out(m_edges, m_valid, m_a, m_b, m_res);
    if (load) begin
      m_a = int'(op_a);
      m_b = int'(op_b);
      m_res = int'({cout, sum});
      m_valid = 1;
    end
    m_edges++;
    exp_q.push_back({m_valid, o});
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit l, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s, input logic c);
    load = l;
    op_a = a;
    op_b = b;
    sum  = s;
    cout = c;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({valid, dig_en, dp, seg} !== 13'h0) begin
      bad++;
      $display("FAIL reset_vals: got %h exp 0000", {valid, dig_en, dp, seg});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    logic [12:0] e;
    for (int i = 0; i < 20; i++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if ({valid, dig_en, dp, seg} !== e) begin
        bad++;
        $display("FAIL idle[%0d]: got %h exp %h", i, {valid, dig_en, dp, seg}, e);
      end
    end
  endtask

  // Directed load plus fixed per-digit patterns from the display rules.
  task automatic test_vector(input string name, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] s, input logic c,
                             input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [12:0] e;
    logic [3:0] seen;
    logic [6:0] want;
    seen = 4'h0;
    drive(1, a, b, s, c);
    tick();
    drive(0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    total++;
    if ({valid, dig_en, dp, seg} !== e) begin
      bad++;
      $display("FAIL %s_load: got %h exp %h", name, {valid, dig_en, dp, seg}, e);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if ({valid, dig_en, dp, seg} !== e) begin
        bad++;
        $display("FAIL %s_model[%0d]: got %h exp %h", name, i, {valid, dig_en, dp, seg}, e);
      end
      want = 7'h00;
      case (dig_en)
        4'b0001: want = e0;
        4'b0010: want = e1;
        4'b0100: want = e2;
        4'b1000: want = e3;
        default: want = 7'h00;
      endcase
      seen = seen | dig_en;
      total++;
      if (seg !== want || dp !== ((dig_en == 4'b0001) ? c : 1'b0) || valid !== 1'b1) begin
        bad++;
        $display("FAIL %s_digit: dig=%b got seg=%h dp=%b valid=%b exp seg=%h dp=%b valid=1",
                 name, dig_en, seg, dp, valid, want, (dig_en == 4'b0001) ? c : 1'b0);
      end
    end
    total++;
    if (seen !== 4'hF) begin
      bad++;
      $display("FAIL %s_coverage: digits seen %b exp 1111", name, seen);
    end
  endtask

  // Each one-hot enable must last exactly SCAN_DIV cycles and rotate 0001->0010->0100->1000.
  task automatic test_scan_timing();
    logic [12:0] e;
    logic [3:0] prev;
    int run;
    bit started;
    prev = dig_en;
    run = 0;
    started = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if ({valid, dig_en, dp, seg} !== e) begin
        bad++;
        $display("FAIL scan_model[%0d]: got %h exp %h", i, {valid, dig_en, dp, seg}, e);
      end
      if (dig_en === prev) begin
        run++;
      end else begin
        if (started) begin
          total++;
          if (run != SCAN_DIV) begin
            bad++;
            $display("FAIL scan_len: digit %b held %0d exp %0d", prev, run, SCAN_DIV);
          end
        end
        total++;
        if (dig_en !== {prev[2:0], prev[3]}) begin
          bad++;
          $display("FAIL scan_order: got %b after %b exp %b", dig_en, prev, {prev[2:0], prev[3]});
        end
        started = 1;
        run = 1;
        prev = dig_en;
      end
    end
  endtask

  // Load on the terminal-count cycle: the next output has both the new index and the new data.
  task automatic test_tc_load();
    logic [12:0] e;
    int nd;
    for (int i = 0; i < 8 && (m_edges % SCAN_DIV) != SCAN_DIV - 1; i++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if ({valid, dig_en, dp, seg} !== e) begin
        bad++;
        $display("FAIL tc_pre[%0d]: got %h exp %h", i, {valid, dig_en, dp, seg}, e);
      end
    end
    drive(1, 4'hC, 4'h4, 4'h9, 1'b1);  // res = 25
    tick();
    drive(0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    total++;
    if ({valid, dig_en, dp, seg} !== e) begin
      bad++;
      $display("FAIL tc_edge: got %h exp %h", {valid, dig_en, dp, seg}, e);
    end
    nd = (m_edges / SCAN_DIV) % 4;
    tick();
    e = exp_q.pop_front();
    total++;
    if ({valid, dig_en, dp, seg} !== e) begin
      bad++;
      $display("FAIL tc_next: got %h exp %h", {valid, dig_en, dp, seg}, e);
    end
    total++;
    if (dig_en !== 4'(1 << nd)) begin
      bad++;
      $display("FAIL tc_digit: got %b exp %b", dig_en, 4'(1 << nd));
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      tick();
      e = exp_q.pop_front();
      total++;
      if ({valid, dig_en, dp, seg} !== e) begin
        bad++;
        $display("FAIL random[%0d]: got %h exp %h", i, {valid, dig_en, dp, seg}, e);
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    bit first_seen;
    tick();
    e = exp_q.pop_front();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({valid, dig_en, dp, seg} !== 13'h0) begin
      bad++;
      $display("FAIL rst_async: got %h exp 0000", {valid, dig_en, dp, seg});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({valid, dig_en, dp, seg} !== 13'h0) begin
      bad++;
      $display("FAIL rst_hold: got %h exp 0000", {valid, dig_en, dp, seg});
    end
    rst_n = 1'b1;
    model_reset();
    drive(1, 4'h1, 4'h2, 4'h3, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    total++;
    if ({valid, dig_en, dp, seg} !== e) begin
      bad++;
      $display("FAIL rst_load: got %h exp %h", {valid, dig_en, dp, seg}, e);
    end
    first_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if ({valid, dig_en, dp, seg} !== e) begin
        bad++;
        $display("FAIL rst_scan[%0d]: got %h exp %h", i, {valid, dig_en, dp, seg}, e);
      end
      if (!first_seen && dig_en !== 4'b0000) begin
        first_seen = 1;
        total++;
        if (dig_en !== 4'b0001) begin
          bad++;
          $display("FAIL rst_first_digit: got %b exp 0001", dig_en);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_vector("res16", 4'h7, 4'h9, 4'h0, 1'b1, 7'h7D, 7'h06, 7'h6F, 7'h07);
    test_vector("res5",  4'h2, 4'h3, 4'h5, 1'b0, 7'h6D, 7'h00, 7'h4F, 7'h5B);
    test_vector("res30", 4'hF, 4'hF, 4'hE, 1'b1, 7'h3F, 7'h4F, 7'h71, 7'h71);
    test_vector("res31", 4'hA, 4'h0, 4'hF, 1'b1, 7'h06, 7'h4F, 7'h3F, 7'h77);
    test_scan_timing();
    test_tc_load();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
